comma_aligned_deserializer: RTL and testbench



---
 rtl/comma_aligned_deserializer_pkg.sv | 21 ++
 rtl/comma_aligned_deserializer_bit_counter_mod10.sv | 26 ++
 rtl/comma_aligned_deserializer.sv | 125 ++++++++++++
 tb/tb_comma_aligned_deserializer.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/comma_aligned_deserializer_pkg.sv
// Shared constants, state encoding and helpers for the comma-aligned deserializer.
package comma_aligned_deserializer_pkg;

  localparam int unsigned SYMBOL_W  = 10;
  localparam int unsigned BIT_CNT_W = 4;
  localparam int unsigned STATS_W   = 16;

  localparam logic [SYMBOL_W-1:0] K285_RD_NEG = 10'b0011111010;
  localparam logic [SYMBOL_W-1:0] K285_RD_POS = ~K285_RD_NEG;

  typedef enum logic [1:0] {
    BUSCANDO     = 2'd0,
    ADQUIRIENDO  = 2'd1,
    SINCRONIZADO = 2'd2
  } sync_state_t;

  function automatic logic [STATS_W-1:0] sat_inc16(input logic [STATS_W-1:0] v);
    return (&v) ? v : v + STATS_W'(1);
  endfunction

endpackage

// File: rtl/comma_aligned_deserializer_bit_counter_mod10.sv
// Symbol bit position counter (0..9) with sync realign-to-0 and a boundary flag.
module bit_counter_mod10
  import comma_aligned_deserializer_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic enb,
  input  logic load,
  output logic boundary_c
);

  logic [BIT_CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (enb) begin
      if (load || boundary_c) cnt <= '0;
      else                    cnt <= cnt + BIT_CNT_W'(1);
    end
  end

  // The last bit of a symbol is sampled on the edge where the count reads 9.
  assign boundary_c = (cnt == BIT_CNT_W'(SYMBOL_W - 1));

endmodule

// File: rtl/comma_aligned_deserializer.sv
// Serial-to-parallel stage with K28.5 boundary alignment and lock/unlock sync FSM.
// Optional COMMA_ALIGNER_STATS_EN adds the saturating realign counter `realineos`.
module comma_aligned_deserializer
  import comma_aligned_deserializer_pkg::*;
#(
  parameter int unsigned LOCK_COMMAS = 3,
  parameter int unsigned UNLOCK_ERRS = 2,
  parameter int unsigned CNT_W       = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enb,
  input  logic                entrada,
  input  logic                esk285,
  output logic [SYMBOL_W-1:0] dato,
  output logic                datoValido,
  output logic                esComa,
  output logic                sincronizado,
  output logic                errorAlineacion
`ifdef COMMA_ALIGNER_STATS_EN
  ,
  output logic [STATS_W-1:0]  realineos
`endif
);

  sync_state_t         state;
  logic [SYMBOL_W-2:0] shreg;
  logic [CNT_W-1:0]    comma_cnt;
  logic [CNT_W-1:0]    err_cnt;
  logic [CNT_W-1:0]    comma_inc_c;
  logic [CNT_W-1:0]    err_inc_c;
  logic                boundary_c;
  logic                load_c;

  assign comma_inc_c = (&comma_cnt) ? comma_cnt : comma_cnt + CNT_W'(1);
  assign err_inc_c   = (&err_cnt)   ? err_cnt   : err_cnt   + CNT_W'(1);

  // Alignment is (re)set by any comma while searching or off-boundary while acquiring.
  assign load_c = esk285 &&
                  ((state == BUSCANDO) || ((state == ADQUIRIENDO) && !boundary_c));

  bit_counter_mod10 u_bit_cnt (
    .clk        (clk),
    .rst        (rst),
    .enb        (enb),
    .load       (load_c),
    .boundary_c (boundary_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= BUSCANDO;
      shreg           <= '0;
      comma_cnt       <= '0;
      err_cnt         <= '0;
      dato            <= '0;
      datoValido      <= 1'b0;
      esComa          <= 1'b0;
      sincronizado    <= 1'b0;
      errorAlineacion <= 1'b0;
`ifdef COMMA_ALIGNER_STATS_EN
      realineos       <= '0;
`endif
    end else begin
      datoValido      <= 1'b0;
      errorAlineacion <= 1'b0;
      if (enb) begin
        shreg <= {shreg[SYMBOL_W-3:0], entrada};
        unique case (state)
          BUSCANDO: begin
            if (esk285) begin
              comma_cnt <= CNT_W'(1);
              if (LOCK_COMMAS <= 1) begin
                state        <= SINCRONIZADO;
                sincronizado <= 1'b1;
                err_cnt      <= '0;
              end else begin
                state <= ADQUIRIENDO;
              end
            end
          end
          ADQUIRIENDO: begin
            if (esk285 && boundary_c) begin
              comma_cnt <= comma_inc_c;
              if (comma_inc_c >= CNT_W'(LOCK_COMMAS)) begin
                state        <= SINCRONIZADO;
                sincronizado <= 1'b1;
                err_cnt      <= '0;
              end
            end else if (esk285) begin
              comma_cnt <= CNT_W'(1);
`ifdef COMMA_ALIGNER_STATS_EN
              realineos <= sat_inc16(realineos);
`endif
            end
          end
          SINCRONIZADO: begin
            if (boundary_c) begin
              dato       <= {shreg, entrada};
              datoValido <= 1'b1;
              esComa     <= esk285;
              if (esk285) err_cnt <= '0;
            end else if (esk285) begin
              // Misaligned comma: flag it but keep the established alignment.
              errorAlineacion <= 1'b1;
              if (err_inc_c >= CNT_W'(UNLOCK_ERRS)) begin
                state        <= BUSCANDO;
                sincronizado <= 1'b0;
                comma_cnt    <= '0;
                err_cnt      <= '0;
`ifdef COMMA_ALIGNER_STATS_EN
                realineos    <= sat_inc16(realineos);
`endif
              end else begin
                err_cnt <= err_inc_c;
              end
            end
          end
          default: state <= BUSCANDO;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_comma_aligned_deserializer.sv
// Directed self-checking bench for comma_aligned_deserializer with a behavioural K28.5 detector.
module tb_comma_aligned_deserializer;

  localparam logic [9:0] COMMA = 10'b0011111010;
  localparam logic [9:0] DATA  = 10'b1110100010;

  logic       clk = 1'b0;
  logic       rst;
  logic       enb;
  logic       entrada;
  logic       esk285;
  logic [9:0] dato;
  logic       datoValido;
  logic       esComa;
  logic       sincronizado;
  logic       errorAlineacion;
`ifdef COMMA_ALIGNER_STATS_EN
  logic [15:0] realineos;
`endif

  logic [8:0] hist;
  int n_tests = 0;
  int n_fail  = 0;
  int vcnt    = 0;
  int v0;

  comma_aligned_deserializer dut (
    .clk             (clk),
    .rst             (rst),
    .enb             (enb),
    .entrada         (entrada),
    .esk285          (esk285),
    .dato            (dato),
    .datoValido      (datoValido),
    .esComa          (esComa),
    .sincronizado    (sincronizado),
    .errorAlineacion (errorAlineacion)
`ifdef COMMA_ALIGNER_STATS_EN
    ,
    .realineos       (realineos)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one bit; esk285 mirrors the detector over the last 10 enabled samples.
  task automatic send_bit(input logic b);
    entrada = b;
    esk285  = enb && ({hist, b} == COMMA);
    @(posedge clk);
    if (enb) hist = {hist[7:0], b};
    #1;
    if (datoValido === 1'b1) vcnt++;
  endtask

  task automatic send_range(input logic [9:0] w, input int first, input int count);
    for (int i = first; i < first + count; i++) send_bit(w[9-i]);
  endtask

  task automatic send_sym(input logic [9:0] w);
    send_range(w, 0, 10);
  endtask

  task automatic send_zeros(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    send_bit(1'b0);
    rst  = 1'b0;
    hist = '0;
  endtask

  task automatic lock_up(input string tag);
    send_zeros(10);
    send_sym(COMMA);
    send_sym(COMMA);
    check({tag, "_pre_sync"}, 16'(sincronizado), 16'd0);
    send_sym(COMMA);
    check({tag, "_sync"}, 16'(sincronizado), 16'd1);
  endtask

  initial begin
    rst = 1'b1; enb = 1'b1; entrada = 1'b0; esk285 = 1'b0; hist = '0;

    // Reset hold with random serial data
    for (int i = 0; i < 8; i++) begin
      send_bit(1'($urandom_range(0, 1)));
      check("rst_dato", 16'(dato), 16'd0);
      check("rst_flags", 16'({datoValido, esComa, sincronizado, errorAlineacion}), 16'd0);
    end
    rst  = 1'b0;
    hist = '0;

    // Lock on three aligned commas with a data symbol between the 2nd and 3rd
    send_zeros(10);
    v0 = vcnt;
    send_sym(COMMA);
    check("lock_c1_sync", 16'(sincronizado), 16'd0);
    send_sym(COMMA);
    check("lock_c2_sync", 16'(sincronizado), 16'd0);
    send_sym(DATA);
    send_range(COMMA, 0, 9);
    check("lock_c3_early", 16'(sincronizado), 16'd0);
    send_range(COMMA, 9, 1);
    check("lock_c3_sync", 16'(sincronizado), 16'd1);
    check("lock_no_valid", 16'(vcnt - v0), 16'd0);
    v0 = vcnt;
    send_sym(DATA);
    check("lock_d_valid", 16'(datoValido), 16'd1);
    check("lock_d_dato", 16'(dato), 16'(DATA));
    check("lock_d_coma", 16'(esComa), 16'd0);
    check("lock_d_strobes", 16'(vcnt - v0), 16'd1);
    send_sym(COMMA);
    check("lock_k_dato", 16'(dato), 16'(COMMA));
    check("lock_k_coma", 16'(esComa), 16'd1);

    // Realign during acquisition: second comma 13 bits after the first
    do_reset();
    send_zeros(10);
    v0 = vcnt;
    send_sym(COMMA);
    send_zeros(3);
    send_sym(COMMA);
    send_sym(COMMA);
    check("realign_c2_sync", 16'(sincronizado), 16'd0);
    send_range(COMMA, 0, 9);
    check("realign_c3_early", 16'(sincronizado), 16'd0);
    send_range(COMMA, 9, 1);
    check("realign_c3_sync", 16'(sincronizado), 16'd1);
    check("realign_no_valid", 16'(vcnt - v0), 16'd0);
`ifdef COMMA_ALIGNER_STATS_EN
    check("realign_stats", realineos, 16'd1);
`endif

    // Unlock: two commas 4 bits off the symbol boundary
    send_sym(DATA);
    check("unlock_d_dato", 16'(dato), 16'(DATA));
    send_zeros(4);
    send_sym(COMMA);
    check("unlock_e1_pulse", 16'(errorAlineacion), 16'd1);
    check("unlock_e1_sync", 16'(sincronizado), 16'd1);
    send_sym(COMMA);
    check("unlock_e2_pulse", 16'(errorAlineacion), 16'd1);
    check("unlock_e2_sync", 16'(sincronizado), 16'd0);
    check("unlock_e2_valid", 16'(datoValido), 16'd0);
    v0 = vcnt;
    send_bit(1'b0);
    check("unlock_pulse_end", 16'(errorAlineacion), 16'd0);
    send_zeros(20);
    check("unlock_no_valid", 16'(vcnt - v0), 16'd0);
`ifdef COMMA_ALIGNER_STATS_EN
    check("unlock_stats", realineos, 16'd2);
`endif

    // Enable gating mid-symbol
    do_reset();
`ifdef COMMA_ALIGNER_STATS_EN
    check("reset_stats", realineos, 16'd0);
`endif
    lock_up("enb_lock");
    send_sym(DATA);
    check("enb_d_dato", 16'(dato), 16'(DATA));
    send_range(COMMA, 0, 4);
    enb = 1'b0;
    for (int i = 0; i < 7; i++) begin
      send_bit(1'(i));
      check("enb_hold_valid", 16'(datoValido), 16'd0);
      check("enb_hold_dato", 16'(dato), 16'(DATA));
    end
    enb = 1'b1;
    send_range(COMMA, 4, 5);
    check("enb_bit9_valid", 16'(datoValido), 16'd0);
    send_range(COMMA, 9, 1);
    check("enb_done_valid", 16'(datoValido), 16'd1);
    check("enb_done_dato", 16'(dato), 16'(COMMA));
    check("enb_done_coma", 16'(esComa), 16'd1);

    // Mid-symbol reset while synchronised
    send_range(DATA, 0, 5);
    do_reset();
    check("mrst_dato", 16'(dato), 16'd0);
    check("mrst_flags", 16'({datoValido, esComa, sincronizado, errorAlineacion}), 16'd0);
`ifdef COMMA_ALIGNER_STATS_EN
    check("mrst_stats", realineos, 16'd0);
`endif
    lock_up("mrst_relock");
    send_sym(DATA);
    check("mrst_d_valid", 16'(datoValido), 16'd1);
    check("mrst_d_dato", 16'(dato), 16'(DATA));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
